// File: rtl/jk_flip_flop_core_if.sv
// ---------------------------------------------------------------------------
// jk_flip_flop_core_if
//   Bundles the data-side signals of a JK flip-flop bank so that a producer
//   (driving J/K) and the bank (driving Q/Qbar) can be connected through a
//   single port. clk and rst are not part of the bundle.
//
//   Signals (all WIDTH bits):
//     J     per-bit set request, driven by the master
//     K     per-bit clear request, driven by the master
//     Q     registered state, driven by the flip-flop bank (slave)
//     Qbar  bitwise complement of Q, driven by the flip-flop bank (slave)
//
//   Modports:
//     master  drives J/K, observes Q/Qbar
//     slave   observes J/K, drives Q/Qbar
// ---------------------------------------------------------------------------
interface jk_flip_flop_core_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;

  modport master (
    output J,
    output K,
    input  Q,
    input  Qbar
  );

  modport slave (
    input  J,
    input  K,
    output Q,
    output Qbar
  );
endinterface : jk_flip_flop_core_if

// File: rtl/jk_flip_flop_core.sv
// ---------------------------------------------------------------------------
// jk_flip_flop_core
//   Bank of WIDTH independent positive-edge JK flip-flops sharing one clock
//   and one asynchronous active-high reset.
//
//   Per bit, on each rising clk edge while rst is low:
//     J=0 K=0 hold, J=0 K=1 clear, J=1 K=0 set, J=1 K=1 toggle.
//   While rst is high the state is forced to RESET_VALUE without waiting for
//   a clock edge. The first rising edge after rst falls evaluates J/K.
//
//   Parameters:
//     WIDTH        number of independent JK bits (>= 1)
//     RESET_VALUE  WIDTH-bit value loaded into Q by reset
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  slave side of jk_flip_flop_core_if (J, K in; Q, Qbar out)
// ---------------------------------------------------------------------------
module jk_flip_flop_core #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
  jk_flip_flop_core_if.slave  bus
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  // Next-state decode, one independent slice per bit. Bits never look at
  // each other, so a per-bit generate keeps that independence explicit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign q_next[gi] = (bus.J[gi] &  bus.K[gi]) ? ~q_reg[gi] :
                          (bus.J[gi] & ~bus.K[gi]) ? 1'b1       :
                          (~bus.J[gi] & bus.K[gi]) ? 1'b0       :
                                                     q_reg[gi];
    end
  endgenerate

  // Single state register for the whole bank; reset is asynchronous so Q
  // reaches RESET_VALUE without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= RESET_VALUE;
    end else begin
      q_reg <= q_next;
    end
  end

  // Qbar is derived from the same register rather than a second flop, so
  // the two outputs can never disagree.
  assign bus.Q    = q_reg;
  assign bus.Qbar = ~q_reg;

endmodule : jk_flip_flop_core

// File: tb/tb_jk_flip_flop_core.sv
// ---------------------------------------------------------------------------
// tb_jk_flip_flop_core
//   Two instances: a 1-bit bank with default reset, and a 4-bit bank with
//   RESET_VALUE = 4'b1010. A fixed timeline with literal expectations comes
//   first, then randomized J/K/rst traffic checked every falling edge
//   against a per-bit truth-table model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jk_flip_flop_core;

  localparam logic [3:0] RV4 = 4'b1010;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  logic       chk_en = 1'b0;
  logic [0:0] exp1;
  logic [3:0] exp4;

  jk_flip_flop_core_if #(.WIDTH(1)) bus1 ();
  jk_flip_flop_core_if #(.WIDTH(4)) bus4 ();

  jk_flip_flop_core #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  jk_flip_flop_core #(.WIDTH(4), .RESET_VALUE(RV4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
    end else begin
      $display("ok   %s t=%0t value=%b", name, $time, act);
    end
  endtask

  // Reference: JK truth table applied to each bit independently.
  function automatic logic [3:0] jk_model(input logic [3:0] q, input logic [3:0] j,
                                          input logic [3:0] k, input int w);
    logic [3:0] r;
    r = q;
    for (int i = 0; i < w; i++) begin
      if (j[i] && k[i])      r[i] = ~q[i];
      else if (j[i])         r[i] = 1'b1;
      else if (k[i])         r[i] = 1'b0;
      else                   r[i] = q[i];
    end
    return r;
  endfunction

  // Per-cycle comparison against the model during the random phase.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_q1",    {3'b000, bus1.Q},    {3'b000, exp1});
      check("cyc_qbar1", {3'b000, bus1.Qbar}, {3'b000, ~exp1});
      check("cyc_q4",    bus4.Q,    exp4);
      check("cyc_qbar4", bus4.Qbar, ~exp4);
    end
  end

  initial begin
    int rst_left;
    logic [3:0] j4, k4;
    logic       j1, k1;

    // ---------------- directed timeline (literal expectations) ----------
    rst = 1'b1;
    bus1.J = 1'b0; bus1.K = 1'b0;
    bus4.J = 4'b0; bus4.K = 4'b0;
    #2;
    check("rst_q1",    {3'b0, bus1.Q},    4'b0000);
    check("rst_qbar1", {3'b0, bus1.Qbar}, 4'b0001);
    check("rst_q4",    bus4.Q,    4'b1010);
    check("rst_qbar4", bus4.Qbar, 4'b0101);
    #5;                                    // t=7, past edge at 5, rst held
    check("rst_hold_q1", {3'b0, bus1.Q}, 4'b0000);
    #3 rst = 1'b0;                         // t=10
    #10;                                   // t=20
    check("hold_q1", {3'b0, bus1.Q}, 4'b0000);
    bus1.J = 1'b0; bus1.K = 1'b1;
    bus4.J = 4'b0011; bus4.K = 4'b0101;
    #10;                                   // t=30
    check("clr_q1",    {3'b0, bus1.Q},    4'b0000);
    check("clr_qbar1", {3'b0, bus1.Qbar}, 4'b0001);
    check("mix_q4",    bus4.Q,    4'b1011);
    check("mix_qbar4", bus4.Qbar, 4'b0100);
    bus1.J = 1'b1; bus1.K = 1'b0;
    bus4.J = 4'b0; bus4.K = 4'b0;
    #10;                                   // t=40
    check("set_q1",    {3'b0, bus1.Q},    4'b0001);
    check("set_qbar1", {3'b0, bus1.Qbar}, 4'b0000);
    check("hold_q4",   bus4.Q,    4'b1011);
    bus1.J = 1'b1; bus1.K = 1'b1;
    #10;                                   // t=50
    check("tog_q1",    {3'b0, bus1.Q},    4'b0000);
    check("tog_qbar1", {3'b0, bus1.Qbar}, 4'b0001);
    rst = 1'b1;
    #1;                                    // t=51, no edge since rst rose
    check("async_q1", {3'b0, bus1.Q}, 4'b0000);
    check("async_q4", bus4.Q, 4'b1010);
    #9;                                    // t=60, edge 55 under reset
    check("rst_mid_q1", {3'b0, bus1.Q}, 4'b0000);
    rst = 1'b0;
    #10;                                   // t=70, edge 65 toggles
    check("post_rst_q1",    {3'b0, bus1.Q},    4'b0001);
    check("post_rst_qbar1", {3'b0, bus1.Qbar}, 4'b0000);
    check("post_rst_q4",    bus4.Q, 4'b1010);
    #10;                                   // t=80, J=K=1 held
    check("tog2_q1", {3'b0, bus1.Q}, 4'b0000);

    // Asynchronous reset while toggling, with Q=0 -> force a set first so
    // the async check is meaningful.
    #1 bus1.J = 1'b1; bus1.K = 1'b0; bus4.J = 4'b0101; bus4.K = 4'b0000;
    @(posedge clk); #1;
    check("pre_async_q1", {3'b0, bus1.Q}, 4'b0001);
    check("pre_async_q4", bus4.Q, 4'b1111);
    rst = 1'b1;
    #1;
    check("async2_q1", {3'b0, bus1.Q}, 4'b0000);
    check("async2_q4", bus4.Q, 4'b1010);
    @(negedge clk); #1;
    rst = 1'b0;

    // ---------------- randomized phase against the model ----------------
    exp1 = 1'b0;
    exp4 = RV4;
    rst_left = 0;
    chk_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      // Occasionally hold J=K=1 everywhere to exercise divide-by-2 runs.
      if ($urandom_range(0, 7) == 0) begin
        j1 = 1'b1; k1 = 1'b1; j4 = 4'hF; k4 = 4'hF;
      end else begin
        j1 = 1'($urandom); k1 = 1'($urandom);
        j4 = 4'($urandom); k4 = 4'($urandom);
      end
      bus1.J = j1; bus1.K = k1;
      bus4.J = j4; bus4.K = k4;

      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        rst_left = $urandom_range(1, 3);
        rst = 1'b1;
        exp1 = 1'b0;
        exp4 = RV4;
        #1;
        check("rnd_async_q1", {3'b0, bus1.Q}, 4'b0000);
        check("rnd_async_q4", bus4.Q, RV4);
      end

      @(posedge clk);
      if (!rst) begin
        exp1 = jk_model({3'b0, exp1}, {3'b0, j1}, {3'b0, k1}, 1);
        exp4 = jk_model(exp4, j4, k4, 4);
      end
      @(negedge clk);
      #1;
    end
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_jk_flip_flop_core
